// File: rtl/ps2_scan_ctrl_if.sv
// Receiver pop handshake and event-queue drain handshake for ps2_scan_ctrl.
// The slave modport is the controller side; master is the receiver/register side.
interface ps2_scan_ctrl_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          rx_ready;
    logic [7:0]    rx_data;
    logic          rx_overflow;
    logic          rx_nextdata_n;
    logic          ev_valid;
    logic [9:0]    ev_data;
    logic          ev_pop;
    logic [CW-1:0] ev_count;

    modport master (
        output rx_ready, rx_data, rx_overflow, ev_pop,
        input  rx_nextdata_n, ev_valid, ev_data, ev_count
    );

    modport slave (
        input  rx_ready, rx_data, rx_overflow, ev_pop,
        output rx_nextdata_n, ev_valid, ev_data, ev_count
    );
endinterface

// File: rtl/ps2_scan_ctrl.sv
// PS/2 set-2 scan sequencer: pops receiver bytes, folds E0/F0 prefixes into key events,
// optionally drops typematic repeats, and queues events for the register front end.
module ps2_scan_ctrl #(
    parameter int unsigned DEPTH         = 4,
    parameter bit          REPEAT_FILTER = 1'b1
) (
    input  logic i_clock,
    input  logic i_clrn,
    input  logic i_enable,
    input  logic i_flush,
    input  logic i_irq_en,
    input  logic i_err_clr,
    ps2_scan_ctrl_if.slave bus,
    output logic o_err,
    output logic o_irq
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} state_t;

    state_t        r_state;
    logic [9:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_lm_valid;
    logic [8:0]    r_lm_key;
    logic          r_err;
    logic          r_irq;

    state_t        w_state_d;
    logic          w_full;
    logic          w_consume;
    logic          w_is_e0;
    logic          w_is_f0;
    logic          w_emit;
    logic          w_ev_ext;
    logic          w_ev_brk;
    logic          w_proto_err;
    logic [9:0]    w_ev;
    logic [8:0]    w_key;
    logic          w_drop;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_count_d;

    assign w_full    = (r_count == FULL);
    // Gated by reset so the receiver is never popped while the controller is held in reset.
    assign w_consume = i_clrn & bus.rx_ready & i_enable & ~i_flush & ~w_full;
    assign w_is_e0   = (bus.rx_data == 8'hE0);
    assign w_is_f0   = (bus.rx_data == 8'hF0);

    always_comb begin
        w_state_d   = r_state;
        w_emit      = 1'b0;
        w_ev_ext    = 1'b0;
        w_ev_brk    = 1'b0;
        w_proto_err = 1'b0;
        if (i_flush) begin
            w_state_d = StIdle;
        end else if (w_consume) begin
            unique case (r_state)
                StIdle: begin
                    if (w_is_e0) begin
                        w_state_d = StExt;
                    end else if (w_is_f0) begin
                        w_state_d = StBrk;
                    end else begin
                        w_emit = 1'b1;
                    end
                end
                StExt: begin
                    w_state_d = StIdle;
                    if (w_is_f0) begin
                        w_state_d = StExtBrk;
                    end else if (w_is_e0) begin
                        w_proto_err = 1'b1;
                    end else begin
                        w_emit   = 1'b1;
                        w_ev_ext = 1'b1;
                    end
                end
                StBrk, StExtBrk: begin
                    w_state_d = StIdle;
                    if (w_is_e0 || w_is_f0) begin
                        w_proto_err = 1'b1;
                    end else begin
                        w_emit   = 1'b1;
                        w_ev_ext = (r_state == StExtBrk);
                        w_ev_brk = 1'b1;
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    assign w_ev   = {w_ev_ext, w_ev_brk, bus.rx_data};
    assign w_key  = {w_ev_ext, bus.rx_data};
    assign w_drop = REPEAT_FILTER && w_emit && !w_ev_brk && r_lm_valid && (r_lm_key == w_key);
    assign w_push = w_emit & ~w_drop;
    assign w_pop  = bus.ev_pop & (r_count != '0) & ~i_flush;

    always_comb begin
        w_count_d = r_count;
        if (i_flush) begin
            w_count_d = '0;
        end else if (w_push && !w_pop) begin
            w_count_d = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_d = r_count - 1'b1;
        end
    end

    always_ff @(posedge i_clock or negedge i_clrn) begin
        if (!i_clrn) begin
            r_state    <= StIdle;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_lm_valid <= 1'b0;
            r_lm_key   <= '0;
            r_err      <= 1'b0;
            r_irq      <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_state <= w_state_d;
            r_count <= w_count_d;
            r_irq   <= i_irq_en & (w_count_d != '0);
            if (w_proto_err || bus.rx_overflow) begin
                r_err <= 1'b1;
            end else if (i_err_clr) begin
                r_err <= 1'b0;
            end
            if (i_flush) begin
                r_wptr     <= '0;
                r_rptr     <= '0;
                r_lm_valid <= 1'b0;
            end else begin
                if (w_push) begin
                    r_mem[r_wptr] <= w_ev;
                    r_wptr        <= r_wptr + 1'b1;
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + 1'b1;
                end
                if (REPEAT_FILTER && w_emit) begin
                    if (!w_ev_brk && !w_drop) begin
                        r_lm_valid <= 1'b1;
                        r_lm_key   <= w_key;
                    end else if (w_ev_brk && r_lm_valid && (r_lm_key == w_key)) begin
                        r_lm_valid <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.rx_nextdata_n = ~w_consume;
    assign bus.ev_valid      = (r_count != '0);
    assign bus.ev_data       = (r_count != '0) ? r_mem[r_rptr] : 10'h000;
    assign bus.ev_count      = r_count;
    assign o_err             = r_err;
    assign o_irq             = r_irq;
endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// Directed bench for ps2_scan_ctrl: byte stream in, expected events scoreboarded and
// compared as they leave the queue. A second instance runs with the repeat filter off.
module tb_ps2_scan_ctrl;
    logic clk;
    logic clrn;
    logic en_main;
    logic en_nf;
    logic flush;
    logic irq_en;
    logic err_clr;
    logic err;
    logic irq;
    logic nf_err;
    logic nf_irq;
    logic nf_pop;

    int checks;
    int errors;
    int npop;
    logic last_consumed;

    logic [7:0] rx_q[$];
    logic [9:0] exp_q[$];
    logic [9:0] exp_nf[$];
    logic [7:0] junk8;
    logic [9:0] junk10;

    ps2_scan_ctrl_if #(.DEPTH(4)) bus ();
    ps2_scan_ctrl_if #(.DEPTH(8)) nf_bus ();

    ps2_scan_ctrl #(.DEPTH(4), .REPEAT_FILTER(1'b1)) dut (
        .i_clock  (clk),
        .i_clrn   (clrn),
        .i_enable (en_main),
        .i_flush  (flush),
        .i_irq_en (irq_en),
        .i_err_clr(err_clr),
        .bus      (bus),
        .o_err    (err),
        .o_irq    (irq)
    );

    ps2_scan_ctrl #(.DEPTH(8), .REPEAT_FILTER(1'b0)) dut_nf (
        .i_clock  (clk),
        .i_clrn   (clrn),
        .i_enable (en_nf),
        .i_flush  (flush),
        .i_irq_en (irq_en),
        .i_err_clr(err_clr),
        .bus      (nf_bus),
        .o_err    (nf_err),
        .o_irq    (nf_irq)
    );

    assign nf_bus.rx_ready    = bus.rx_ready;
    assign nf_bus.rx_data     = bus.rx_data;
    assign nf_bus.rx_overflow = bus.rx_overflow;
    assign nf_bus.ev_pop      = nf_pop;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $error("FAIL timeout: observed no finish, expected finish");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_rx();
        bus.rx_ready = (rx_q.size() != 0);
        bus.rx_data  = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
    endtask

    task automatic put(input logic [7:0] b);
        rx_q.push_back(b);
        drive_rx();
    endtask

    // Inputs are applied 1 time unit after the edge; outputs sampled there too.
    task automatic tick();
        #1;
        last_consumed = (bus.rx_nextdata_n == 1'b0) || (nf_bus.rx_nextdata_n == 1'b0);
        @(posedge clk);
        #1;
        if (last_consumed && rx_q.size() != 0) junk8 = rx_q.pop_front();
        drive_rx();
    endtask

    task automatic feed_all(input int budget);
        int n = 0;
        while (rx_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("feed_done", rx_q.size(), 0);
    endtask

    task automatic drain_all(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || rx_q.size() != 0 || bus.ev_valid) && n < budget) begin
            if (bus.ev_valid) begin
                if (exp_q.size() == 0) begin
                    chk("extra_event", bus.ev_valid, 0);
                end else begin
                    chk("ev_data", bus.ev_data, exp_q[0]);
                    junk10 = exp_q.pop_front();
                end
                bus.ev_pop = 1'b1;
            end else begin
                bus.ev_pop = 1'b0;
            end
            tick();
            n++;
        end
        bus.ev_pop = 1'b0;
        chk("drain_done", exp_q.size(), 0);
        chk("drain_empty", bus.ev_count, 0);
    endtask

    task automatic nf_drain(input int budget);
        int n = 0;
        while ((exp_nf.size() != 0 || nf_bus.ev_valid) && n < budget) begin
            if (nf_bus.ev_valid) begin
                if (exp_nf.size() == 0) begin
                    chk("nf_extra_event", nf_bus.ev_valid, 0);
                end else begin
                    chk("nf_ev_data", nf_bus.ev_data, exp_nf[0]);
                    junk10 = exp_nf.pop_front();
                end
                nf_pop = 1'b1;
            end else begin
                nf_pop = 1'b0;
            end
            tick();
            n++;
        end
        nf_pop = 1'b0;
        chk("nf_drain_done", exp_nf.size(), 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        npop = 0;
        clrn = 1'b0;
        en_main = 1'b0;
        en_nf = 1'b0;
        flush = 1'b0;
        irq_en = 1'b0;
        err_clr = 1'b0;
        nf_pop = 1'b0;
        bus.rx_overflow = 1'b0;
        bus.ev_pop = 1'b0;
        drive_rx();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ev_valid", bus.ev_valid, 0);
        chk("rst_ev_count", bus.ev_count, 0);
        chk("rst_ev_data", bus.ev_data, 0);
        chk("rst_err", err, 0);
        chk("rst_irq", irq, 0);
        chk("rst_nextdata_n", bus.rx_nextdata_n, 1);
        clrn = 1'b1;
        en_main = 1'b1;
        irq_en = 1'b1;

        // Make then break of 1C, back to back.
        put(8'h1C); put(8'hF0); put(8'h1C);
        exp_q.push_back(10'h01C); exp_q.push_back(10'h11C);
        tick(); npop += int'(last_consumed);
        chk("t1_count_1", bus.ev_count, 1);
        tick(); npop += int'(last_consumed);
        tick(); npop += int'(last_consumed);
        chk("t1_pops", npop, 3);
        chk("t1_count_2", bus.ev_count, 2);
        chk("t1_irq", irq, 1);
        drain_all(20);
        chk("t1_irq_off", irq, 0);

        // Extended make/break; a lone E0 held across enable=0 yields nothing.
        put(8'hE0);
        tick();
        chk("t2_lone_e0", bus.ev_valid, 0);
        en_main = 1'b0;
        put(8'h75);
        repeat (3) tick();
        chk("t2_held_byte", rx_q.size(), 1);
        chk("t2_held_noev", bus.ev_valid, 0);
        en_main = 1'b1;
        put(8'hE0); put(8'hF0); put(8'h75);
        exp_q.push_back(10'h275); exp_q.push_back(10'h375);
        feed_all(20);
        chk("t2_count", bus.ev_count, 2);
        chk("t2_head", bus.ev_data, 10'h275);
        tick();
        chk("t2_head_stable", bus.ev_data, 10'h275);
        drain_all(20);

        // Repeat filter on the main instance.
        put(8'h1C); put(8'h1C); put(8'h1C); put(8'hF0); put(8'h1C); put(8'h1C);
        exp_q.push_back(10'h01C); exp_q.push_back(10'h11C); exp_q.push_back(10'h01C);
        feed_all(20);
        chk("t3_count", bus.ev_count, 3);
        drain_all(20);

        // Same stream into the unfiltered instance.
        en_main = 1'b0;
        en_nf = 1'b1;
        put(8'h1C); put(8'h1C); put(8'h1C); put(8'hF0); put(8'h1C); put(8'h1C);
        exp_nf.push_back(10'h01C); exp_nf.push_back(10'h01C); exp_nf.push_back(10'h01C);
        exp_nf.push_back(10'h11C); exp_nf.push_back(10'h01C);
        feed_all(20);
        chk("t3_nf_count", nf_bus.ev_count, 5);
        nf_drain(20);
        en_nf = 1'b0;
        en_main = 1'b1;

        // Fill to DEPTH, check back-pressure, then drain 10 events through the wrap.
        begin
            logic [7:0] codes [10];
            codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44, 8'h4D};
            for (int i = 0; i < 10; i++) begin
                put(codes[i]);
                exp_q.push_back({2'b00, codes[i]});
            end
        end
        repeat (4) tick();
        chk("t4_full", bus.ev_count, 4);
        bus.ev_pop = 1'b1;
        #1;
        chk("t4_blocked", bus.rx_nextdata_n, 1);
        chk("t4_head", bus.ev_data, exp_q[0]);
        junk10 = exp_q.pop_front();
        tick();
        bus.ev_pop = 1'b0;
        chk("t4_count_3", bus.ev_count, 3);
        #1;
        chk("t4_resume", bus.rx_nextdata_n, 0);
        drain_all(60);

        // Protocol error and err set/clear priority.
        put(8'hF0); put(8'hF0);
        feed_all(20);
        chk("t5_err", err, 1);
        chk("t5_noev", bus.ev_valid, 0);
        err_clr = 1'b1;
        bus.rx_overflow = 1'b1;
        tick();
        chk("t5_set_wins", err, 1);
        bus.rx_overflow = 1'b0;
        tick();
        chk("t5_cleared", err, 0);
        err_clr = 1'b0;

        // Flush with two events queued and the decoder mid-prefix.
        put(8'h1C); put(8'h2C); put(8'hE0);
        feed_all(20);
        chk("t6_count", bus.ev_count, 2);
        chk("t6_irq", irq, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        exp_q.delete();
        chk("t6_valid", bus.ev_valid, 0);
        chk("t6_fcount", bus.ev_count, 0);
        chk("t6_firq", irq, 0);
        put(8'h1C);
        exp_q.push_back(10'h01C);
        drain_all(20);

        // Asynchronous reset mid-sequence.
        put(8'h24);
        tick();
        chk("t7_count", bus.ev_count, 1);
        bus.rx_overflow = 1'b1;
        tick();
        bus.rx_overflow = 1'b0;
        chk("t7_err", err, 1);
        put(8'h2C);
        clrn = 1'b0;
        #1;
        chk("t7_rst_valid", bus.ev_valid, 0);
        chk("t7_rst_count", bus.ev_count, 0);
        chk("t7_rst_data", bus.ev_data, 0);
        chk("t7_rst_err", err, 0);
        chk("t7_rst_irq", irq, 0);
        chk("t7_rst_nextdata_n", bus.rx_nextdata_n, 1);
        rx_q.delete();
        exp_q.delete();
        drive_rx();
        tick();
        clrn = 1'b1;
        tick();
        chk("t7_post_valid", bus.ev_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
